// File: rtl/vend_sequencer.sv
// Vending sequencer: validates a sale, drives the dispense motor once per item,
// then pays change greedily through a $5 and a $1 hopper with per-request timeouts.
module vend_sequencer #(
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] total,
  input  logic [7:0] paid,
  input  logic [1:0] quantity,
  input  logic       item_ack,
  input  logic       coin_ack,
  output logic       motor_en,
  output logic       coin5_req,
  output logic       coin1_req,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] items_left,
  output logic [7:0] change_left
);

  localparam int CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, CHECK, ITEM, ITEM_GAP, COIN, COIN_GAP, DONE, FAULT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    total_q, paid_q, total_n, paid_n;
  logic [1:0]    qty_q, qty_n;
  logic          motor_n, c5_n, c1_n, busy_n, done_n, fault_n;
  logic [1:0]    items_n;
  logic [7:0]    change_n;
  logic          go_item, go_coin, go_done, go_fault;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    total_n  = total_q;
    paid_n   = paid_q;
    qty_n    = qty_q;
    motor_n  = motor_en;
    c5_n     = coin5_req;
    c1_n     = coin1_req;
    busy_n   = busy;
    done_n   = 1'b0;
    fault_n  = fault;
    items_n  = items_left;
    change_n = change_left;
    go_item  = 1'b0;
    go_coin  = 1'b0;
    go_done  = 1'b0;
    go_fault = 1'b0;

    case (state)
      IDLE: if (start) begin
        state_n  = CHECK;
        total_n  = total;
        paid_n   = paid;
        qty_n    = quantity;
        items_n  = quantity;
        change_n = paid - total;
        fault_n  = 1'b0;
        busy_n   = 1'b1;
      end
      CHECK: begin
        if (paid_q < total_q || qty_q == 2'd0) go_fault = 1'b1;
        else if (items_left != 2'd0)          go_item  = 1'b1;
        else                                  go_done  = 1'b1;
      end
      // An ack on the expiry cycle is checked first so it wins over the timeout.
      ITEM: begin
        if (item_ack) begin
          motor_n = 1'b0;
          if (items_left != 2'd0) items_n = items_left - 2'd1;
          state_n = ITEM_GAP;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) go_fault = 1'b1;
        else cnt_n = cnt + 1'b1;
      end
      ITEM_GAP: begin
        if (cnt == GAP_LAST) begin
          if (items_left != 2'd0)       go_item = 1'b1;
          else if (change_left != 8'd0) go_coin = 1'b1;
          else                          go_done = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      COIN: begin
        if (coin_ack) begin
          c5_n = 1'b0;
          c1_n = 1'b0;
          if (coin5_req && change_left >= 8'd5)       change_n = change_left - 8'd5;
          else if (coin1_req && change_left != 8'd0)  change_n = change_left - 8'd1;
          state_n = COIN_GAP;
          cnt_n   = '0;
        end else if (cnt == TO_LAST) go_fault = 1'b1;
        else cnt_n = cnt + 1'b1;
      end
      COIN_GAP: begin
        if (cnt == GAP_LAST) begin
          if (change_left != 8'd0) go_coin = 1'b1;
          else                     go_done = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      DONE, FAULT: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    // Entry actions are shared by every path into the target state.
    if (go_item) begin
      state_n = ITEM;
      motor_n = 1'b1;
      cnt_n   = '0;
    end
    if (go_coin) begin
      state_n = COIN;
      c5_n    = (change_left >= 8'd5);
      c1_n    = (change_left <  8'd5);
      cnt_n   = '0;
    end
    if (go_done) begin
      state_n = DONE;
      done_n  = 1'b1;
    end
    if (go_fault) begin
      state_n = FAULT;
      motor_n = 1'b0;
      c5_n    = 1'b0;
      c1_n    = 1'b0;
      fault_n = 1'b1;
      done_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      total_q     <= '0;
      paid_q      <= '0;
      qty_q       <= '0;
      motor_en    <= 1'b0;
      coin5_req   <= 1'b0;
      coin1_req   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      items_left  <= '0;
      change_left <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      total_q     <= total_n;
      paid_q      <= paid_n;
      qty_q       <= qty_n;
      motor_en    <= motor_n;
      coin5_req   <= c5_n;
      coin1_req   <= c1_n;
      busy        <= busy_n;
      done        <= done_n;
      fault       <= fault_n;
      items_left  <= items_n;
      change_left <= change_n;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a per-sale expected-output timeline is built
// from the pricing/dispense rules and compared against the DUT every cycle.
module tb_vend_sequencer;
  localparam int TO = 20;
  localparam int GP = 2;

  logic       clk = 1'b0;
  logic       reset, start, item_ack, coin_ack;
  logic [7:0] total, paid;
  logic [1:0] quantity;
  logic       motor_en, coin5_req, coin1_req, busy, done, fault;
  logic [1:0] items_left;
  logic [7:0] change_left;

  always #5 clk = ~clk;

  vend_sequencer #(.TIMEOUT(TO), .GAP(GP)) dut (
    .clk(clk), .reset(reset), .start(start), .total(total), .paid(paid),
    .quantity(quantity), .item_ack(item_ack), .coin_ack(coin_ack),
    .motor_en(motor_en), .coin5_req(coin5_req), .coin1_req(coin1_req),
    .busy(busy), .done(done), .fault(fault), .items_left(items_left),
    .change_left(change_left)
  );

  typedef struct packed {
    logic       motor, c5, c1, busy, done, fault;
    logic [1:0] items;
    logic [7:0] change;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur = '0;
  exp_t got;
  int   checks = 0, errors = 0, cyc = 0;
  bit   chk_en = 0;
  int   mot_rise = 0, c5_rise = 0, c1_rise = 0, mot_hi = 0, done_at = 0;
  logic pm = 1'b0, p5 = 1'b0, p1 = 1'b0;
  int   ack_d = 3;
  bit   stray = 0;
  int   ic = 0, cc = 0;
  int   s0, dm, d5, d1, dhi, drel;

  // Hopper/sensor emulation: ack in the ack_d-th cycle a request is held high.
  initial begin
    item_ack = 1'b0;
    coin_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      ic = (motor_en === 1'b1) ? ic + 1 : 0;
      cc = (coin5_req === 1'b1 || coin1_req === 1'b1) ? cc + 1 : 0;
      item_ack = ((motor_en === 1'b1) && ack_d != 0 && ic == ack_d) ||
                 (stray && motor_en !== 1'b1);
      coin_ack = (cc != 0 && ack_d != 0 && cc == ack_d) || (stray && cc == 0);
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic push_n(input exp_t e, input int n);
    repeat (n) q.push_back(e);
  endtask

  task automatic finish_fault(input exp_t e);
    e.motor = 0; e.c5 = 0; e.c1 = 0; e.fault = 1; e.done = 1;
    q.push_back(e);
    e.done = 0; e.busy = 0;
    q.push_back(e);
  endtask

  // Timeline of outputs for the cycles after start is accepted.
  task automatic build(input logic [7:0] t, input logic [7:0] p, input logic [1:0] qn, input int d);
    exp_t e;
    int   ch, coin;
    e = '0; e.busy = 1; e.items = qn; e.change = p - t;
    q.push_back(e);
    if (p < t || qn == 0) begin finish_fault(e); return; end
    for (int i = 0; i < qn; i++) begin
      e.motor = 1;
      if (d == 0) begin push_n(e, TO); finish_fault(e); return; end
      push_n(e, d);
      e.motor = 0; e.items = e.items - 2'd1;
      push_n(e, GP);
    end
    ch = int'(e.change);
    while (ch > 0) begin
      coin = (ch >= 5) ? 5 : 1;
      e.c5 = (coin == 5); e.c1 = (coin == 1);
      if (d == 0) begin push_n(e, TO); finish_fault(e); return; end
      push_n(e, d);
      ch = ch - coin;
      e.c5 = 0; e.c1 = 0; e.change = 8'(ch);
      push_n(e, GP);
    end
    e.done = 1; q.push_back(e);
    e.done = 0; e.busy = 0; q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d want 0 entries left", q.size());
      q.delete();
    end
  endtask

  task automatic vend(input logic [7:0] t, input logic [7:0] p, input logic [1:0] qn, input int d);
    int bm, b5, b1, bh;
    ack_d = d;
    @(posedge clk); #1;
    total = t; paid = p; quantity = qn; start = 1;
    @(posedge clk); #1;
    start = 0; s0 = cyc;
    bm = mot_rise; b5 = c5_rise; b1 = c1_rise; bh = mot_hi;
    build(t, p, qn, d);
    wait_drain();
    dm = mot_rise - bm; d5 = c5_rise - b5; d1 = c1_rise - b1; dhi = mot_hi - bh;
    drel = done_at - s0;
  endtask

  initial begin
    reset = 1; start = 0; total = 0; paid = 0; quantity = 0;
    q.push_back('0);
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
          if (q.size() > 0) exp_cur = q.pop_front();
          got = {motor_en, coin5_req, coin1_req, busy, done, fault, items_left, change_left};
          checks++;
          if (got !== exp_cur) begin
            errors++;
            $display("FAIL outputs cyc %0d got %h want %h", cyc, got, exp_cur);
          end
        end
        if (motor_en === 1'b1 && !pm) mot_rise++;
        if (coin5_req === 1'b1 && !p5) c5_rise++;
        if (coin1_req === 1'b1 && !p1) c1_rise++;
        if (motor_en === 1'b1) mot_hi++;
        if (done === 1'b1) done_at = cyc;
        pm = (motor_en === 1'b1); p5 = (coin5_req === 1'b1); p1 = (coin1_req === 1'b1);
      end
    join_none

    @(posedge clk); #1; chk_en = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (2) @(posedge clk);

    vend(8'd12, 8'd20, 2'd1 + 2'd1, 3);
    chk("sale_20_12_done_at", drel, 32);
    chk("sale_20_12_motor_pulses", dm, 2);
    chk("sale_20_12_coin5", d5, 1);
    chk("sale_20_12_coin1", d1, 3);

    vend(8'd6, 8'd6, 2'd1, 3);
    chk("exact_pay_done_at", drel, 7);
    chk("exact_pay_coins", d5 + d1, 0);

    vend(8'd10, 8'd5, 2'd1, 3);
    chk("underpay_done_at", drel, 2);
    chk("underpay_motor", dm, 0);
    chk("underpay_fault", int'(fault), 1);

    vend(8'd5, 8'd5, 2'd0, 3);
    chk("qty0_done_at", drel, 2);

    vend(8'd0, 8'd0, 2'd1, 0);
    chk("timeout_done_at", drel, 22);
    chk("timeout_motor_cycles", dhi, TO);
    chk("timeout_items_left", int'(items_left), 1);
    chk("timeout_fault_sticky", int'(fault), 1);

    vend(8'd3, 8'd4, 2'd1, TO);
    chk("ack_at_expiry_done_at", drel, 46);

    vend(8'd0, 8'd7, 2'd3, 1);
    chk("greedy7_done_at", drel, 20);
    chk("greedy7_coin5", d5, 1);
    chk("greedy7_coin1", d1, 2);

    stray = 1;
    repeat (3) @(posedge clk);
    vend(8'd2, 8'd13, 2'd1, 2);
    stray = 0;
    chk("stray_done_at", drel, 18);
    chk("stray_coin5", d5, 2);
    chk("stray_coin1", d1, 1);

    // Reset in the middle of a $5 request, together with start and coin_ack.
    ack_d = 3;
    @(posedge clk); #1;
    total = 0; paid = 10; quantity = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    build(8'd0, 8'd10, 2'd1, 3);
    begin
      int n = 0;
      while (coin5_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("coin5_seen", int'(coin5_req === 1'b1), 1);
    end
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1;
    reset = 0; start = 0;
    q.delete(); q.push_back('0);
    @(negedge clk);
    chk("reset_coin5", int'(coin5_req), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_change", int'(change_left), 0);
    repeat (3) @(posedge clk);

    vend(8'd1, 8'd2, 2'd1, 1);
    chk("after_reset_done_at", drel, 8);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000: maximum cycles to wait for any acknowledge before faulting.
REQ-002 SHALL have parameter GAP, default 2: idle cycles inserted between consecutive request pulses.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a vend; sampled only in IDLE.
REQ-006 SHALL have port total, input, 8: total price in dollars, latched on accepted start.
REQ-007 SHALL have port paid, input, 8: entered amount in dollars, latched on accepted start.
REQ-008 SHALL have port quantity, input, 2: item count 0-3, latched on accepted start.
REQ-009 SHALL have port item_ack, input, 1: dispense sensor; high means one item dropped.
REQ-010 SHALL have port coin_ack, input, 1: coin hopper confirms one coin released.
REQ-011 SHALL have port motor_en, output, 1: dispense motor drive, held until item_ack.
REQ-012 SHALL have port coin5_req and coin1_req, outputs, 1 each: $5 and $1 hopper requests, held until coin_ack.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at the end of every accepted or rejected vend.
REQ-015 SHALL have port fault, output, 1: sticky error flag, cleared by the next accepted start or by reset.
REQ-016 SHALL have ports items_left (2) and change_left (8), outputs: live remaining counts for display.

Function
REQ-017 SHALL implement states IDLE, CHECK, ITEM, ITEM_GAP, COIN, COIN_GAP, DONE, FAULT, with all outputs registered.
REQ-018 IDLE: start=1 latches inputs, sets items_left=quantity and change_left=paid-total (8-bit), clears fault, and goes to CHECK; start while busy SHALL be ignored.
REQ-019 CHECK (one cycle): paid<total or quantity==0 -> FAULT; else items_left>0 -> ITEM.
REQ-020 ITEM: motor_en=1 starting the cycle after entering; item_ack=1 -> motor_en=0 next cycle, items_left decrements, go to ITEM_GAP.
REQ-021 ITEM_GAP: GAP cycles all requests low; then items_left>0 -> ITEM, else change_left>0 -> COIN, else DONE.
REQ-022 COIN: change_left>=5 -> coin5_req=1, else coin1_req=1; never both high in the same cycle; coin_ack=1 -> request drops next cycle, change_left decreases by 5 or 1 accordingly, go to COIN_GAP.
REQ-023 COIN_GAP: GAP cycles idle; then change_left>0 -> COIN, else DONE.
REQ-024 Change SHALL use the greedy method: floor(change/5) $5 coins followed by (change mod 5) $1 coins.
REQ-025 Each wait in ITEM and COIN SHALL count cycles; reaching TIMEOUT without ack -> FAULT; an ack arriving on the expiry cycle wins over the timeout.
REQ-026 FAULT: all requests low, fault=1, done pulse for one cycle, then IDLE; items_left and change_left hold their values for diagnosis.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE with busy=0.
REQ-028 item_ack outside ITEM and coin_ack outside COIN SHALL be ignored, with no count change.
REQ-029 Counters SHALL never wrap: items_left and change_left only decrement when >0.

Reset
REQ-030 reset=1 SHALL force IDLE on the next edge, from any state including mid-request.
REQ-031 reset=1 SHALL clear all outputs and counters to 0 on the next edge.
REQ-032 reset SHALL take priority over start and over both acks in the same cycle.

Verification
REQ-033 total=12, paid=20, qty=2, ack each request after 3 cycles -> 2 motor_en pulses, then coin5 x1, coin1 x3, then done, fault=0, change_left=0.
REQ-034 total=6, paid=6, qty=1 -> one motor_en pulse, no coin requests, done one cycle after GAP expires.
REQ-035 total=10, paid=5, qty=1 -> no motor_en and no requests, fault=1, done pulse two cycles after start.
REQ-036 qty=1 with item_ack never asserted -> motor_en high for TIMEOUT cycles, then FAULT with items_left=1, then IDLE with fault still 1.
REQ-037 reset pulsed while coin5_req=1 -> coin5_req=0, busy=0, change_left=0 on the next edge; a second start pulse while busy has no effect.
